// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-client memory arbiter: FSM states, client index
// and the registered read-response tag.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef logic client_t;

    typedef struct packed {
        logic    valid;
        client_t idx;
    } rsp_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client and memory-side signal bundle for mem_arbiter; the arbiter takes the
// slave view, the client/memory environment the master view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 2
) ();

    logic                  req0, req1;
    logic                  lock0, lock1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  mem_wr, mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_wr, mem_re, mem_addr, mem_din
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_wr, mem_re, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// on a tie the pointer decides. Output is one-hot or zero.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  client_t    ptr,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | (ptr == 1'b0));
    assign gnt[1] = req[1] & (~req[0] | (ptr == 1'b1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two
// clients, with bounded locked bursts and a tagged 1-cycle read return path.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int MAX_BURST  = 4
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);
    localparam bit                 LOCK_EN   = (MAX_BURST > 1);

    state_t                state;
    client_t               rr_ptr;
    logic [BURST_W-1:0]    burst_cnt;
    rsp_tag_t              rsp_p1;

    logic [1:0]            pick_gnt;
    logic [1:0]            gnt;
    logic                  gnt_any;
    client_t               sel;
    logic                  sel_we, sel_lock;
    logic                  own_req, own_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  rv0, rv1;

    rr_pick2 u_pick (
        .req (({bus.req1, bus.req0})),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    // While owned, only the owner is eligible; grants are suppressed in reset.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (state)
                IDLE:    gnt = pick_gnt;
                OWN0:    gnt = {1'b0, bus.req0};
                OWN1:    gnt = {bus.req1, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt_any   = |gnt;
    assign sel       = gnt[1];
    assign sel_we    = sel ? bus.we1    : bus.we0;
    assign sel_lock  = sel ? bus.lock1  : bus.lock0;
    assign sel_addr  = sel ? bus.addr1  : bus.addr0;
    assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;
    assign own_req   = (state == OWN1) ? bus.req1  : bus.req0;
    assign own_lock  = (state == OWN1) ? bus.lock1 : bus.lock0;

    assign bus.gnt0     = gnt[0];
    assign bus.gnt1     = gnt[1];
    assign bus.mem_wr   = gnt_any &  sel_we;
    assign bus.mem_re   = gnt_any & ~sel_we;
    assign bus.mem_addr = gnt_any ? sel_addr  : '0;
    assign bus.mem_din  = gnt_any ? sel_wdata : '0;

    // Stage p1: memory data arrives, steered by the tag captured at grant.
    assign rv0         = rsp_p1.valid & (rsp_p1.idx == 1'b0);
    assign rv1         = rsp_p1.valid & (rsp_p1.idx == 1'b1);
    assign bus.rvalid0 = rv0;
    assign bus.rvalid1 = rv1;
    assign bus.rdata0  = rv0 ? bus.mem_dout : '0;
    assign bus.rdata1  = rv1 ? bus.mem_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            rsp_p1    <= '0;
        end else begin
            rsp_p1.valid <= bus.mem_re;
            rsp_p1.idx   <= sel;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr <= ~sel;
                        if (LOCK_EN && sel_lock) begin
                            state     <= sel ? OWN1 : OWN0;
                            burst_cnt <= BURST_W'(1);
                        end
                    end
                end
                OWN0, OWN1: begin
                    // Saturated counter or dropped lock/req hands control back.
                    if (own_req && own_lock && (burst_cnt < LAST_BEAT)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle registered memory.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   fails;
    logic [1:0] mem [4];

    mem_arbiter_if #(.DATA_WIDTH(2), .ADDR_WIDTH(2)) bus ();

    mem_arbiter #(.DATA_WIDTH(2), .ADDR_WIDTH(2), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_re) bus.mem_dout <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        bus.we0 = 0; bus.we1 = 0; bus.addr0 = 0; bus.addr1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0;
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd0; mem[3] = 2'd2;
        bus.mem_dout = 2'd0;
        clear_inputs();
        rst_n = 1'b0;
        bus.req0 = 1;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rvalid1", bus.rvalid1, 0);
        rst_n = 1'b1;
        clear_inputs();

        // Single write from client 0, then read it back through client 1
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2; bus.wdata0 = 3; #1;
        chk("wr_gnt0", bus.gnt0, 1);
        chk("wr_gnt1", bus.gnt1, 0);
        chk("wr_mem_wr", bus.mem_wr, 1);
        chk("wr_mem_re", bus.mem_re, 0);
        chk("wr_mem_addr", bus.mem_addr, 2);
        chk("wr_mem_din", bus.mem_din, 3);
        @(negedge clk);
        clear_inputs();
        bus.req1 = 1; bus.addr1 = 2; #1;
        chk("rd_gnt1", bus.gnt1, 1);
        chk("rd_mem_re", bus.mem_re, 1);
        chk("wr_no_rvalid0", bus.rvalid0, 0);
        @(negedge clk);
        clear_inputs(); #1;
        chk("rd_rvalid1", bus.rvalid1, 1);
        chk("rd_rdata1", bus.rdata1, 3);
        chk("rd_rdata0_zero", bus.rdata0, 0);

        // Contention without lock: grants alternate starting with client 0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req0 = 1; bus.addr0 = 0; bus.req1 = 1; bus.addr1 = 1; #1;
            chk("alt_gnt0", bus.gnt0, (k % 2 == 0));
            chk("alt_gnt1", bus.gnt1, (k % 2 == 1));
            chk("alt_wr_re_excl", bus.mem_wr & bus.mem_re, 0);
            if (k > 0) begin
                chk("alt_rvalid0", bus.rvalid0, (k % 2 == 1));
                chk("alt_rvalid1", bus.rvalid1, (k % 2 == 0));
                chk("alt_rdata", bus.rdata0 | bus.rdata1, (k % 2 == 1) ? 8'd1 : 8'd3);
            end
        end
        @(negedge clk);
        clear_inputs(); #1;
        chk("alt_last_rvalid1", bus.rvalid1, 1);
        chk("alt_last_rdata1", bus.rdata1, 3);

        // Locked burst saturates after 4 beats, then client 1 gets through
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req0 = 1; bus.lock0 = 1; bus.req1 = 1; #1;
            chk("burst_gnt0", bus.gnt0, (c < 4));
            chk("burst_gnt1", bus.gnt1, (c == 4));
        end
        @(negedge clk);
        clear_inputs();

        // Lock for two beats, drop lock: third beat still to 0, then 1 wins
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.req0 = 1; bus.req1 = 1; bus.lock0 = (c < 2); #1;
            chk("unlock_gnt0", bus.gnt0, (c < 3));
            chk("unlock_gnt1", bus.gnt1, (c == 3));
        end
        @(negedge clk);
        clear_inputs();

        // Reset while a read to client 1 is in flight, with rr_ptr moved to 1
        @(negedge clk);
        bus.req0 = 1; bus.addr0 = 0; #1;
        chk("pre_rst_gnt0", bus.gnt0, 1);
        @(negedge clk);
        clear_inputs();
        bus.req1 = 1; bus.addr1 = 1; #1;
        chk("pre_rst_gnt1", bus.gnt1, 1);
        chk("pre_rst_rvalid0", bus.rvalid0, 1);
        chk("pre_rst_rdata0", bus.rdata0, 1);
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_rvalid1", bus.rvalid1, 0);
        chk("midrst_gnt1", bus.gnt1, 0);
        chk("midrst_mem_re", bus.mem_re, 0);
        rst_n = 1'b1;
        bus.req0 = 1; bus.req1 = 1; #1;
        chk("postrst_tie_gnt0", bus.gnt0, 1);
        chk("postrst_tie_gnt1", bus.gnt1, 0);
        @(negedge clk);
        clear_inputs();

        // Write then immediate read of the same address from the other client
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 1; bus.wdata0 = 2'b10; #1;
        chk("raw_gnt0", bus.gnt0, 1);
        chk("raw_mem_wr", bus.mem_wr, 1);
        @(negedge clk);
        clear_inputs();
        bus.req1 = 1; bus.addr1 = 1; #1;
        chk("raw_gnt1", bus.gnt1, 1);
        chk("raw_mem_addr", bus.mem_addr, 1);
        @(negedge clk);
        clear_inputs(); #1;
        chk("raw_rvalid1", bus.rvalid1, 1);
        chk("raw_rdata1", bus.rdata1, 2);
        chk("raw_rvalid0", bus.rvalid0, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
